// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-ported SRAM between an instruction-fetch
// port and a load/store port. Data has priority; a starvation counter forces
// an instruction grant after STARVE_LIMIT consecutive denied fetch cycles.
// Read data returns exactly one cycle after the grant and is steered to the
// port recorded in a response-owner register.
module sram_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  // instruction fetch port
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic        inst_cancel,
  output logic        inst_gnt,
  output logic        inst_rvalid,
  output logic [31:0] inst_rdata,
  // load/store port
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  // shared SRAM
  output logic        mem_en,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  // Wide enough to hold STARVE_LIMIT, also for a limit of 0.
  localparam int CW = $clog2(STARVE_LIMIT + 2);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_INST,
    OWN_DATA
  } owner_t;

  logic [CW-1:0] starve_cnt;
  owner_t        owner;
  logic          starved;

  assign starved = (starve_cnt == CW'(STARVE_LIMIT));

  // Grant selection and SRAM command mux; everything is forced low in reset.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    inst_gnt  = 1'b0;
    data_gnt  = 1'b0;
    mem_en    = 1'b0;
    mem_wen   = 4'b0000;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    if (!reset) begin
      if (inst_req && (!data_req || starved)) begin
        inst_gnt = 1'b1;
        mem_en   = 1'b1;
        mem_addr = inst_addr;
      end else if (data_req) begin
        data_gnt  = 1'b1;
        mem_en    = 1'b1;
        mem_wen   = data_wen;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
      end
    end
  end

  // Starvation counter and response-owner register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
      owner      <= OWN_NONE;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (inst_req && !inst_gnt) begin
        if (!starved) starve_cnt <= starve_cnt + CW'(1);
      end else begin
        starve_cnt <= '0;
      end

      if (inst_gnt)                          owner <= OWN_INST;
      else if (data_gnt && data_wen == 4'b0) owner <= OWN_DATA;
      else                                   owner <= OWN_NONE;
    end
  end

  // Response steering: a cancel only discards the fetch data returning now.
  assign inst_rvalid = (owner == OWN_INST) && !inst_cancel;
  assign data_rvalid = (owner == OWN_DATA);
  assign inst_rdata  = inst_rvalid ? mem_rdata : 32'd0;
  assign data_rdata  = data_rvalid ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed scenarios plus randomized traffic, each cycle
// compared against a behavioural model of the arbitration rules.
module tb_sram_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_cancel, inst_gnt, inst_rvalid;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_gnt, data_rvalid;
  logic [3:0]  data_wen, mem_wen;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Behavioural model: denied-fetch streak length and who owns the read
  // response returning in the next cycle (0 none, 1 fetch, 2 load).
  int   m_wait = 0;
  int   m_pend = 0;
  logic last_ig;

  sram_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
    .inst_gnt(inst_gnt), .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
    .data_rdata(data_rdata),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=0x%08h expected=0x%08h", tag, cyc, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_inst_gnt"},    32'(inst_gnt),    32'd0);
    check({tag, "_data_gnt"},    32'(data_gnt),    32'd0);
    check({tag, "_inst_rvalid"}, 32'(inst_rvalid), 32'd0);
    check({tag, "_data_rvalid"}, 32'(data_rvalid), 32'd0);
    check({tag, "_inst_rdata"},  inst_rdata,       32'd0);
    check({tag, "_data_rdata"},  data_rdata,       32'd0);
    check({tag, "_mem_en"},      32'(mem_en),      32'd0);
    check({tag, "_mem_wen"},     32'(mem_wen),     32'd0);
    check({tag, "_mem_addr"},    mem_addr,         32'd0);
    check({tag, "_mem_wdata"},   mem_wdata,        32'd0);
  endtask

  // One clock cycle: called at posedge+1, drives inputs, checks every output
  // against the model mid-cycle, advances the model, returns at posedge+1.
  task automatic run_cycle(input logic ir, input logic [31:0] ia, input logic ic,
                           input logic dr, input logic [3:0] dw,
                           input logic [31:0] da, input logic [31:0] dd);
    logic        e_ig, e_dg, e_ir, e_dr;
    logic [31:0] rd;
    inst_req = ir;  inst_addr = ia;  inst_cancel = ic;
    data_req = dr;  data_wen = dw;   data_addr = da;  data_wdata = dd;
    rd = $urandom;
    mem_rdata = rd;

    e_ig = ir && (!dr || m_wait >= STARVE_LIMIT);
    e_dg = dr && !e_ig;
    e_ir = (m_pend == 1) && !ic;
    e_dr = (m_pend == 2);

    #3;
    check("inst_gnt",    32'(inst_gnt),    32'(e_ig));
    check("data_gnt",    32'(data_gnt),    32'(e_dg));
    check("mem_en",      32'(mem_en),      32'(e_ig || e_dg));
    check("mem_wen",     32'(mem_wen),     e_dg ? 32'(dw) : 32'd0);
    check("mem_addr",    mem_addr,         e_ig ? ia : (e_dg ? da : 32'd0));
    check("mem_wdata",   mem_wdata,        e_dg ? dd : 32'd0);
    check("inst_rvalid", 32'(inst_rvalid), 32'(e_ir));
    check("data_rvalid", 32'(data_rvalid), 32'(e_dr));
    check("inst_rdata",  inst_rdata,       e_ir ? rd : 32'd0);
    check("data_rdata",  data_rdata,       e_dr ? rd : 32'd0);
    last_ig = inst_gnt;

    if (ir && !e_ig) m_wait = (m_wait < STARVE_LIMIT) ? m_wait + 1 : STARVE_LIMIT;
    else             m_wait = 0;
    if (e_ig)                    m_pend = 1;
    else if (e_dg && dw == 4'b0) m_pend = 2;
    else                         m_pend = 0;

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    run_cycle(1'b0, 32'd0, 1'b0, 1'b0, 4'b0, 32'd0, 32'd0);
  endtask

  initial begin
    logic [5:0] ig_seen;

    // Reset held with both requests active: every output stays low, no clock needed.
    reset = 1'b1;
    inst_req = 1'b1;  inst_addr = 32'h1234_5678;  inst_cancel = 1'b0;
    data_req = 1'b1;  data_wen = 4'b0;  data_addr = 32'h0000_0040;
    data_wdata = 32'hFFFF_FFFF;  mem_rdata = 32'hA5A5_A5A5;
    #2;
    check_all_zero("reset_hold");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Lone fetch at 0x8000_0000 in the first cycle after reset, data next cycle.
    run_cycle(1'b1, 32'h8000_0000, 1'b0, 1'b0, 4'b0, 32'd0, 32'd0);
    check("first_fetch_gnt", 32'(last_ig), 32'd1);
    idle();

    // Both ports requesting for six cycles: starvation forces fetch in cycle 4.
    for (int i = 0; i < 6; i++) begin
      run_cycle(1'b1, 32'h0000_1000, 1'b0, 1'b1, 4'b0, 32'h0000_2000 + 32'(i * 4), 32'd0);
      ig_seen[i] = last_ig;
    end
    check("starve_pattern", 32'(ig_seen), 32'h10);
    idle();

    // Store grant: strobes and data reach the SRAM, no load response follows.
    run_cycle(1'b0, 32'd0, 1'b0, 1'b1, 4'b0011, 32'h0000_0300, 32'hDEAD_BEEF);
    idle();

    // Load response coinciding with a store grant is still delivered.
    run_cycle(1'b0, 32'd0, 1'b0, 1'b1, 4'b0000, 32'h0000_0400, 32'd0);
    run_cycle(1'b0, 32'd0, 1'b0, 1'b1, 4'b1111, 32'h0000_0404, 32'h0BAD_F00D);
    idle();

    // Fetch N, cancel plus new fetch N+1, normal return N+2.
    run_cycle(1'b1, 32'h0000_0100, 1'b0, 1'b0, 4'b0, 32'd0, 32'd0);
    run_cycle(1'b1, 32'h0000_0200, 1'b1, 1'b0, 4'b0, 32'd0, 32'd0);
    idle();

    // Load granted, then reset pulsed mid-cycle while its response is returning.
    run_cycle(1'b0, 32'd0, 1'b0, 1'b1, 4'b0, 32'h0000_0500, 32'd0);
    inst_req = 1'b0;  inst_cancel = 1'b0;  data_req = 1'b1;  data_wen = 4'b0;
    mem_rdata = 32'h5A5A_5A5A;
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_wait = 0;
    m_pend = 0;
    cyc++;
    idle();
    idle();

    // Randomized traffic, heavy on data to exercise starvation.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] w;
      w = ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom);
      run_cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 4) == 0,
                $urandom_range(0, 4) != 0, w, $urandom, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
